wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Write-back stage; sits directly downstream of the memory-access stage. Accepts one retiring instruction per
//  valid/ready handshake and selects rd data: load data if mem_ren, else execute result. Drives the register-file
//  write port, CSR write port, forwarding bus, retire counter and commit/trace port, and halts the core on ebreak.
// PARAMETERS
//  XLEN         32             data/address width
//  CNT_W        64             width of retired-instruction counter
//  EBREAK_INST  32'h00100073   encoding that triggers halt
// PORTS
//  clk           in   1      clock, all state updates on rising edge
//  rst           in   1      synchronous, active-high reset
//  valid_last    in   1      upstream holds a valid instruction
//  ready_last    out  1      stage can accept this cycle
//  pc            in   XLEN   instruction pc
//  inst          in   32     instruction word
//  R_wen         in   1      instruction writes rd
//  rd            in   5      destination register
//  mem_ren       in   1      instruction is a load
//  MEM_Rdata     in   XLEN   load data, already extended
//  Ex_result     in   XLEN   ALU/CSR-read result
//  csr_wen       in   4      one-hot CSR write select (mstatus/mtvec/mepc/mcause = bit0..3)
//  csrs          in   XLEN   CSR write data
//  jump_flag     in   1      instruction redirected control flow
//  rf_wen        out  1      register-file write enable
//  rf_waddr      out  5      register-file write address
//  rf_wdata      out  XLEN   register-file write data
//  csr_wr_en     out  4      CSR write enables
//  csr_wr_data   out  XLEN   CSR write data
//  fwd_valid     out  1      forwarding bus carries a pending rd write
//  fwd_rd        out  5      forwarding destination
//  fwd_data      out  XLEN   forwarding data
//  commit_valid  out  1      instruction presented for retirement
//  commit_ready  in   1      trace/difftest sink accepts commit
//  commit_pc     out  XLEN   retiring pc
//  commit_inst   out  32     retiring instruction
//  commit_jump   out  1      retiring instruction was a jump
//  minstret      out  CNT_W  retired-instruction count
//  halt          out  1      core halted by ebreak
// BEHAVIOUR
//  - FSM states: IDLE (empty), HOLD (one instruction latched), HALT (terminal until rst).
//  - ready_last = (IDLE) | (HOLD & commit_ready). Forced 0 in HALT. Combinational from state and commit_ready.
//  - accept = valid_last & ready_last. Accepting latches all inputs into the holding register and moves to HOLD.
//  - Write data is selected at latch time: wdata = mem_ren ? MEM_Rdata : Ex_result.
//  - fire = HOLD & commit_ready. fire without accept -> IDLE. fire with accept -> stay HOLD (back-to-back,
//    1 instruction/cycle). fire of inst==EBREAK_INST -> HALT; any same-cycle accept is suppressed.
//  - commit_valid = HOLD. commit_pc/inst/jump show the held fields and stay stable while commit_ready=0.
//  - rf_wen = fire & R_wen_h & (rd_h!=0). No write to x0. rf_waddr = rd_h, rf_wdata = wdata_h.
//  - csr_wr_en = fire ? csr_wen_h : 4'b0. csr_wr_data = csrs_h. rf and csr writes may fire together.
//  - fwd_valid = HOLD & R_wen_h & (rd_h!=0), including cycles stalled on commit_ready. fwd_rd = rd_h,
//    fwd_data = wdata_h.
//  - minstret increments by 1 on each fire, including ebreak. Wraps modulo 2^CNT_W with no flag.
//  - halt = (state==HALT), asserted the cycle after the ebreak fire.
//  - Latency: instruction accepted at edge N is presented at N+1. Its rf write takes effect at the edge where
//    it fires.
//  - Reset values: state=IDLE, holding register=0, minstret=0. All write enables, fwd_valid, commit_valid and
//    halt = 0. ready_last=1 in the first post-reset cycle.
//  - Reset mid-operation (HOLD or HALT): the held instruction is discarded with no rf/csr write and no count.
// TESTING
//  - Reset, then ALU op pc=0x80000000, R_wen=1, rd=5, Ex_result=0x1234 with commit_ready=1 -> next cycle
//    rf_wen=1, rf_waddr=5, rf_wdata=0x1234, minstret=1.
//  - Load: mem_ren=1, MEM_Rdata=0xFFFFFF80, Ex_result=0x80001000, rd=10 -> rf_wdata=0xFFFFFF80.
//    Same with rd=0 -> rf_wen=0, fwd_valid=0, minstret still increments.
//  - 4 back-to-back instructions, commit_ready=1 -> ready_last stays 1 and minstret reaches 4 after 4 fires.
//    Then commit_ready=0 for 3 cycles -> ready_last=0, commit_* and fwd_* stable, no rf_wen.
//  - csr_wen=4'b0100, csrs=0x80000010 -> csr_wr_en=4'b0100 for exactly one cycle, csr_wr_data=0x80000010.
//  - inst=0x00100073 followed by valid_last=1 -> halt=1 next cycle, ready_last=0, following instruction
//    never committed. Assert rst -> halt=0, minstret=0.
//  - Force minstret to 2^64-1, commit one instruction -> minstret=0.

Source files
------------

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- write-back stage
//
// Purpose:
//   Retires one instruction per valid/ready handshake from the memory-access
//   stage. The rd data is chosen when the instruction is latched (load data
//   if mem_ren, otherwise the execute result). Once latched, the instruction
//   is presented on the commit port. It drives the register-file and CSR
//   write ports only in the cycle the commit sink accepts it. An ebreak halts
//   the core until reset.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   valid_last / ready_last        upstream handshake
//   pc, inst, R_wen, rd, mem_ren,
//   MEM_Rdata, Ex_result, csr_wen,
//   csrs, jump_flag                retiring instruction fields
//   rf_wen/rf_waddr/rf_wdata       register-file write port
//   csr_wr_en/csr_wr_data          CSR write port (one-hot mstatus..mcause)
//   fwd_valid/fwd_rd/fwd_data      forwarding bus for the held rd write
//   commit_valid/commit_ready,
//   commit_pc/inst/jump            commit / trace port
//   minstret                       retired-instruction counter
//   halt                           core halted by ebreak
//
// FSM states:
//   state  | meaning
//   IDLE   | holding register empty, ready for a new instruction
//   HOLD   | one instruction latched, waiting for commit_ready
//   HALT   | ebreak retired, terminal until rst
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int          XLEN        = 32,
  parameter int          CNT_W       = 64,
  parameter logic [31:0] EBREAK_INST = 32'h00100073
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             valid_last,
  output logic             ready_last,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      inst,
  input  logic             R_wen,
  input  logic [4:0]       rd,
  input  logic             mem_ren,
  input  logic [XLEN-1:0]  MEM_Rdata,
  input  logic [XLEN-1:0]  Ex_result,
  input  logic [3:0]       csr_wen,
  input  logic [XLEN-1:0]  csrs,
  input  logic             jump_flag,

  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,

  output logic [3:0]       csr_wr_en,
  output logic [XLEN-1:0]  csr_wr_data,

  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,

  output logic             commit_valid,
  input  logic             commit_ready,
  output logic [XLEN-1:0]  commit_pc,
  output logic [31:0]      commit_inst,
  output logic             commit_jump,

  output logic [CNT_W-1:0] minstret,
  output logic             halt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // holding register
  logic [XLEN-1:0]  pc_h;
  logic [31:0]      inst_h;
  logic             r_wen_h;
  logic [4:0]       rd_h;
  logic [XLEN-1:0]  wdata_h;
  logic [3:0]       csr_wen_h;
  logic [XLEN-1:0]  csrs_h;
  logic             jump_h;

  logic [CNT_W-1:0] minstret_q;

  logic is_idle;
  logic is_hold;
  logic is_halt;
  logic fire;
  logic accept;
  logic ebreak_h;
  logic rd_write_h;

  assign is_idle = (state_q == S_IDLE);
  assign is_hold = (state_q == S_HOLD);
  assign is_halt = (state_q == S_HALT);

  assign ebreak_h   = (inst_h == EBREAK_INST);
  assign rd_write_h = r_wen_h & (rd_h != 5'd0);

  // While rst is high the held instruction is being discarded, so nothing
  // may retire or be handed over in that cycle.
  assign ready_last = ~rst & (is_idle | (is_hold & commit_ready));
  assign fire       = ~rst & is_hold & commit_ready;

  // An ebreak leaving the stage blocks any instruction offered in the same
  // cycle; that instruction must never retire.
  assign accept = valid_last & ready_last & ~(fire & ebreak_h);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (fire) begin
          if (ebreak_h) begin
            state_d = S_HALT;
          end else if (accept) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Holding register: write data is resolved here so the forwarding bus
  // carries the final value for the whole time the instruction is held.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_h      <= '0;
      inst_h    <= '0;
      r_wen_h   <= 1'b0;
      rd_h      <= '0;
      wdata_h   <= '0;
      csr_wen_h <= '0;
      csrs_h    <= '0;
      jump_h    <= 1'b0;
    end else if (accept) begin
      pc_h      <= pc;
      inst_h    <= inst;
      r_wen_h   <= R_wen;
      rd_h      <= rd;
      wdata_h   <= mem_ren ? MEM_Rdata : Ex_result;
      csr_wen_h <= csr_wen;
      csrs_h    <= csrs;
      jump_h    <= jump_flag;
    end
  end

  // -------------------------------------------------------------------------
  // Retired-instruction counter, wraps silently
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      minstret_q <= '0;
    end else if (fire) begin
      minstret_q <= minstret_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rf_wen      = fire & rd_write_h;
  assign rf_waddr    = rd_h;
  assign rf_wdata    = wdata_h;

  assign csr_wr_en   = fire ? csr_wen_h : 4'b0000;
  assign csr_wr_data = csrs_h;

  assign fwd_valid   = ~rst & is_hold & rd_write_h;
  assign fwd_rd      = rd_h;
  assign fwd_data    = wdata_h;

  assign commit_valid = ~rst & is_hold;
  assign commit_pc    = pc_h;
  assign commit_inst  = inst_h;
  assign commit_jump  = jump_h;

  assign minstret = minstret_q;
  assign halt     = is_halt;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        valid_last;
  logic        ready_last;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        R_wen;
  logic [4:0]  rd;
  logic        mem_ren;
  logic [31:0] MEM_Rdata;
  logic [31:0] Ex_result;
  logic [3:0]  csr_wen;
  logic [31:0] csrs;
  logic        jump_flag;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  csr_wr_en;
  logic [31:0] csr_wr_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic [31:0] commit_inst;
  logic        commit_jump;
  logic [63:0] minstret;
  logic        halt;

  // narrow-counter instance used to exercise the wrap boundary
  logic        s_ready_last;
  logic        s_rf_wen;
  logic [4:0]  s_rf_waddr;
  logic [31:0] s_rf_wdata;
  logic [3:0]  s_csr_wr_en;
  logic [31:0] s_csr_wr_data;
  logic        s_fwd_valid;
  logic [4:0]  s_fwd_rd;
  logic [31:0] s_fwd_data;
  logic        s_commit_valid;
  logic [31:0] s_commit_pc;
  logic [31:0] s_commit_inst;
  logic        s_commit_jump;
  logic [2:0]  s_minstret;
  logic        s_halt;

  int n_chk;
  int n_fail;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .valid_last(valid_last), .ready_last(ready_last),
    .pc(pc), .inst(inst), .R_wen(R_wen), .rd(rd), .mem_ren(mem_ren),
    .MEM_Rdata(MEM_Rdata), .Ex_result(Ex_result), .csr_wen(csr_wen),
    .csrs(csrs), .jump_flag(jump_flag),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_wr_en(csr_wr_en), .csr_wr_data(csr_wr_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_jump(commit_jump),
    .minstret(minstret), .halt(halt)
  );

  wb_stage #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .valid_last(valid_last), .ready_last(s_ready_last),
    .pc(pc), .inst(inst), .R_wen(R_wen), .rd(rd), .mem_ren(mem_ren),
    .MEM_Rdata(MEM_Rdata), .Ex_result(Ex_result), .csr_wen(csr_wen),
    .csrs(csrs), .jump_flag(jump_flag),
    .rf_wen(s_rf_wen), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
    .csr_wr_en(s_csr_wr_en), .csr_wr_data(s_csr_wr_data),
    .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data),
    .commit_valid(s_commit_valid), .commit_ready(commit_ready),
    .commit_pc(s_commit_pc), .commit_inst(s_commit_inst), .commit_jump(s_commit_jump),
    .minstret(s_minstret), .halt(s_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; outputs are checked
  // on the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic w,
                       input logic [4:0] r, input logic mr, input logic [31:0] md,
                       input logic [31:0] ex, input logic [3:0] cw, input logic [31:0] cd,
                       input logic j);
    valid_last = 1'b1;
    pc = p; inst = i; R_wen = w; rd = r; mem_ren = mr; MEM_Rdata = md;
    Ex_result = ex; csr_wen = cw; csrs = cd; jump_flag = j;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_last = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    valid_last = 0; pc = 0; inst = 0; R_wen = 0; rd = 0; mem_ren = 0;
    MEM_Rdata = 0; Ex_result = 0; csr_wen = 0; csrs = 0; jump_flag = 0;
    commit_ready = 1'b1;
    do_reset();

    // reset state
    sample();
    chk("rst_ready", ready_last, 1);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_halt", halt, 0);
    chk("rst_minstret", minstret, 0);
    chk("rst_rfwen", rf_wen, 0);
    chk("rst_fwd", fwd_valid, 0);
    chk("rst_csr", csr_wr_en, 0);

    // ALU op
    next_cycle();
    drive(32'h8000_0000, 32'h1230_0293, 1, 5'd5, 0, 32'h0, 32'h1234, 4'h0, 32'h0, 1);
    next_cycle();
    valid_last = 1'b0;
    sample();
    chk("alu_cvalid", commit_valid, 1);
    chk("alu_rfwen", rf_wen, 1);
    chk("alu_waddr", rf_waddr, 5);
    chk("alu_wdata", rf_wdata, 32'h1234);
    chk("alu_pc", commit_pc, 32'h8000_0000);
    chk("alu_jump", commit_jump, 1);
    chk("alu_fwd", fwd_valid, 1);
    next_cycle();
    sample();
    chk("alu_minstret", minstret, 1);
    chk("alu_empty", commit_valid, 0);
    chk("alu_rfwen_off", rf_wen, 0);

    // load to rd=10, then load to x0
    next_cycle();
    drive(32'h8000_0004, 32'h0000_2503, 1, 5'd10, 1, 32'hFFFF_FF80, 32'h8000_1000, 4'h0, 32'h0, 0);
    next_cycle();
    drive(32'h8000_0008, 32'h0000_2003, 1, 5'd0, 1, 32'hFFFF_FF80, 32'h8000_1000, 4'h0, 32'h0, 0);
    sample();
    chk("ld_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("ld_fwddata", fwd_data, 32'hFFFF_FF80);
    chk("ld_rfwen", rf_wen, 1);
    next_cycle();
    valid_last = 1'b0;
    sample();
    chk("ldx0_cvalid", commit_valid, 1);
    chk("ldx0_rfwen", rf_wen, 0);
    chk("ldx0_fwd", fwd_valid, 0);
    chk("ldx0_cnt_before", minstret, 2);
    next_cycle();
    sample();
    chk("ldx0_cnt", minstret, 3);

    // back-to-back, then stall
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(32'h8000_0100 + 32'(i * 4), 32'h0000_0013, 1, 5'(i + 1), 0, 32'h0,
            32'h100 + 32'(i), 4'h0, 32'h0, 0);
      sample();
      chk($sformatf("b2b_ready%0d", i), ready_last, 1);
      if (i > 0) begin
        chk($sformatf("b2b_waddr%0d", i), rf_waddr, 5'(i));
        chk($sformatf("b2b_rfwen%0d", i), rf_wen, 1);
      end
      next_cycle();
    end
    drive(32'h8000_0200, 32'h0000_0013, 1, 5'd9, 0, 32'h0, 32'h999, 4'h0, 32'h0, 0);
    commit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("stall_ready", ready_last, 0);
      chk("stall_rfwen", rf_wen, 0);
      chk("stall_pc", commit_pc, 32'h8000_010C);
      chk("stall_fwd", {fwd_valid, fwd_rd, fwd_data}, {1'b1, 5'd4, 32'h103});
      chk("stall_cnt", minstret, 3);
      next_cycle();
    end
    valid_last = 1'b0;
    commit_ready = 1'b1;
    sample();
    chk("unstall_rfwen", rf_wen, 1);
    next_cycle();
    sample();
    chk("b2b_cnt", minstret, 4);
    chk("b2b_empty", commit_valid, 0);

    // CSR write, held one cycle before the sink accepts
    commit_ready = 1'b0;
    drive(32'h8000_0300, 32'h3410_1073, 0, 5'd0, 0, 32'h0, 32'h0, 4'b0100, 32'h8000_0010, 0);
    next_cycle();
    valid_last = 1'b0;
    sample();
    chk("csr_stalled", csr_wr_en, 0);
    next_cycle();
    commit_ready = 1'b1;
    sample();
    chk("csr_en", csr_wr_en, 4'b0100);
    chk("csr_data", csr_wr_data, 32'h8000_0010);
    next_cycle();
    sample();
    chk("csr_once", csr_wr_en, 0);
    chk("csr_cnt", minstret, 5);

    // ebreak followed by another instruction
    drive(32'h8000_0400, 32'h0010_0073, 0, 5'd0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0);
    next_cycle();
    drive(32'h8000_0404, 32'h0000_0393, 1, 5'd7, 0, 32'h0, 32'h77, 4'h0, 32'h0, 0);
    sample();
    chk("ebk_inst", commit_inst, 32'h0010_0073);
    next_cycle();
    sample();
    chk("ebk_halt", halt, 1);
    chk("ebk_ready", ready_last, 0);
    chk("ebk_cvalid", commit_valid, 0);
    chk("ebk_cnt", minstret, 6);
    next_cycle();
    next_cycle();
    sample();
    chk("ebk_stay", {halt, commit_valid, rf_wen}, 3'b100);
    chk("ebk_cnt2", minstret, 6);
    do_reset();
    sample();
    chk("ebk_rst_halt", halt, 0);
    chk("ebk_rst_cnt", minstret, 0);

    // reset while an instruction is held
    commit_ready = 1'b0;
    drive(32'h8000_0500, 32'h0000_0013, 1, 5'd3, 0, 32'h0, 32'h55, 4'b0001, 32'h1, 0);
    next_cycle();
    valid_last = 1'b0;
    rst = 1'b1;
    commit_ready = 1'b1;
    sample();
    chk("midrst_rfwen", rf_wen, 0);
    chk("midrst_csr", csr_wr_en, 0);
    next_cycle();
    rst = 1'b0;
    sample();
    chk("midrst_cvalid", commit_valid, 0);
    chk("midrst_cnt", minstret, 0);

    // counter wrap on the 3-bit instance
    for (int i = 0; i < 8; i++) begin
      drive(32'h8000_0600, 32'h0000_0013, 0, 5'd0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0);
      next_cycle();
    end
    valid_last = 1'b0;
    sample();
    chk("wrap_pre", s_minstret, 7);
    next_cycle();
    sample();
    chk("wrap_zero", s_minstret, 0);
    chk("wrap_wide", minstret, 8);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
